// File: rtl/mcu_fetch_ctrl.sv
// mcu_fetch_ctrl: sequential imem fetch with an in-order response queue,
// redirect flush/drop and halt/resume sequencing toward decode.
// Ports: clk, rst_n (sync, active-low); imem_req_valid/ready/addr;
//   imem_rsp_valid/data; redirect_valid/pc; halt_req, halted;
//   if_valid/ready/pc/instr (queue head to decode).
module mcu_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        halted,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL_C  = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST    = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALTING,
    HALTED
  } state_t;

  state_t state_q, state_d;

  logic [31:0]   fetch_pc_q;
  logic [31:0]   rsp_pc_q;
  logic [CW-1:0] outst_q;
  logic [CW-1:0] drop_q;
  logic [CW-1:0] count_q;
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [31:0]   pc_mem  [FIFO_DEPTH];
  logic [31:0]   ins_mem [FIFO_DEPTH];

  logic [CW:0]   used;
  logic [CW-1:0] outst_nx;
  logic [31:0]   redir_pc;
  logic          issue;
  logic          req_acc;
  logic          rsp_ok;
  logic          push;
  logic          pop;
  logic          head_vld;
  logic          unused_ok;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign redir_pc  = {redirect_pc[31:2], 2'b00};
  assign unused_ok = ^redirect_pc[1:0];

  // Credits count both in-flight requests and
  // queued entries, so a push can never overflow.
  assign used  = {1'b0, outst_q} + {1'b0, count_q};
  assign issue = rst_n && (state_q == RUN)
              && !halt_req && !redirect_valid
              && (drop_q == '0) && (used < DEPTH_W);

  assign req_acc  = issue && imem_req_ready;
  assign rsp_ok   = imem_rsp_valid && (outst_q != '0);
  assign outst_nx = outst_q + CW'(req_acc) - CW'(rsp_ok);

  // Redirect wins over queue writes and pops.
  assign push = rsp_ok && (drop_q == '0)
             && !redirect_valid;
  assign head_vld = (count_q != '0);
  assign pop  = head_vld && if_ready
             && !redirect_valid;

  assign imem_req_valid = issue;
  assign imem_req_addr  = issue ? fetch_pc_q : '0;
  assign if_valid = rst_n && head_vld;
  assign if_pc    = if_valid ? pc_mem[rd_q] : '0;
  assign if_instr = if_valid ? ins_mem[rd_q] : '0;
  assign halted   = rst_n && (state_q == HALTED);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (halt_req) state_d = HALTING;
      end
      HALTING: begin
        if (redirect_valid)
          state_d = halt_req ? HALTING : RUN;
        else if (outst_q == '0)
          state_d = HALTED;
      end
      HALTED: begin
        if (redirect_valid)
          state_d = halt_req ? HALTING : RUN;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
    end else begin
      state_q <= state_d;
      outst_q <= outst_nx;
      if (redirect_valid) begin
        // Everything still in flight belongs
        // to the old path and is discarded.
        fetch_pc_q <= redir_pc;
        rsp_pc_q   <= redir_pc;
        drop_q     <= outst_nx;
        count_q    <= '0;
        wr_q       <= '0;
        rd_q       <= '0;
      end else begin
        if (req_acc)
          fetch_pc_q <= fetch_pc_q + 32'd4;
        if (rsp_ok && (drop_q != '0))
          drop_q <= drop_q - 1'b1;
        if (push) begin
          rsp_pc_q <= rsp_pc_q + 32'd4;
          wr_q     <= nxt(wr_q);
        end
        if (pop)
          rd_q <= nxt(rd_q);
        count_q <= count_q + CW'(push)
                 - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_q]  <= rsp_pc_q;
      ins_mem[wr_q] <= imem_rsp_data;
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count_q == FULL_C))
  );

endmodule

// File: tb/tb_mcu_fetch_ctrl.sv
// tb_mcu_fetch_ctrl: in-order imem model plus a sequential-stream
// reference for mcu_fetch_ctrl, directed scenarios then random traffic.
module tb_mcu_fetch_ctrl;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        halted;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  mcu_fetch_ctrl #(
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt_req      (halt_req),
    .halted        (halted),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_pc         (if_pc),
    .if_instr      (if_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] req_log[$];
  logic [31:0] dl_pc[$];
  logic [31:0] dl_in[$];
  int cyc, last_due, last_rsp, max_pend;
  int lat_min, lat_max;
  int nchk, nerr;

  logic        s_rv, s_iv, s_h;
  logic [31:0] s_ra, s_ipc, s_iin;
  int          s_cyc;

  function automatic logic [31:0] mem_word(
    input logic [31:0] a
  );
    return (a * 32'd3) ^ 32'hDEAD_BEEF;
  endfunction

  // One clock: imem responds in order, outputs are
  // sampled at negedge, handshakes are logged.
  task automatic tick();
    int lat;
    int due;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (rst_n && pend.size() > 0
        && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend[0].addr);
      pend.delete(0);
      last_rsp = cyc;
    end
    @(negedge clk);
    s_rv  = imem_req_valid;
    s_ra  = imem_req_addr;
    s_iv  = if_valid;
    s_ipc = if_pc;
    s_iin = if_instr;
    s_h   = halted;
    s_cyc = cyc;
    if (rst_n && imem_req_valid && imem_req_ready) begin
      lat = int'($urandom_range(lat_max, lat_min));
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{imem_req_addr, due});
      req_log.push_back(imem_req_addr);
      if (pend.size() > max_pend) max_pend = pend.size();
    end
    if (rst_n && if_valid && if_ready && !redirect_valid) begin
      dl_pc.push_back(if_pc);
      dl_in.push_back(if_instr);
    end
    @(posedge clk);
    #1;
    cyc++;
    redirect_valid = 1'b0;
    if (!rst_n) begin
      pend.delete();
      last_due = 0;
    end
  endtask

  task automatic clear_logs();
    req_log.delete();
    dl_pc.delete();
    dl_in.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    halt_req = 1'b0;
    redirect_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    clear_logs();
    max_pend = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    imem_req_ready = 1'b1;
    if_ready = 1'b1;
    lat_min = 1;
    lat_max = 1;
    tick();
    tick();
    nchk++;
    if (s_rv !== 1'b0) begin
      nerr++; $display("FAIL rst_req_valid got %0h want 0", s_rv);
    end
    nchk++;
    if (s_ra !== 32'h0) begin
      nerr++; $display("FAIL rst_req_addr got %0h want 0", s_ra);
    end
    nchk++;
    if (s_iv !== 1'b0 || s_h !== 1'b0) begin
      nerr++; $display("FAIL rst_valid_halted got %0h/%0h want 0/0", s_iv, s_h);
    end
    nchk++;
    if (s_ipc !== 32'h0 || s_iin !== 32'h0) begin
      nerr++; $display("FAIL rst_if_data got %0h/%0h want 0/0", s_ipc, s_iin);
    end
    rst_n = 1'b1;
    clear_logs();
    tick();
    nchk++;
    if (s_rv !== 1'b0) begin
      nerr++; $display("FAIL boot_no_req got %0h want 0", s_rv);
    end
    tick();
    nchk++;
    if (s_rv !== 1'b1 || s_ra !== 32'h0) begin
      nerr++; $display("FAIL first_req got v=%0h a=%0h want v=1 a=0", s_rv, s_ra);
    end
  endtask

  task automatic test_basic();
    logic [31:0] e;
    do_reset();
    imem_req_ready = 1'b1;
    if_ready = 1'b1;
    lat_min = 1;
    lat_max = 1;
    repeat (30) tick();
    nchk++;
    if (dl_pc.size() < 10) begin
      nerr++; $display("FAIL basic_count got %0d want >=10", dl_pc.size());
    end
    e = 32'h0;
    for (int i = 0; i < dl_pc.size(); i++) begin
      nchk++;
      if (dl_pc[i] !== e || dl_in[i] !== mem_word(e)) begin
        nerr++;
        $display("FAIL basic_stream[%0d] got %0h/%0h want %0h/%0h", i, dl_pc[i], dl_in[i], e, mem_word(e));
      end
      e += 32'd4;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    imem_req_ready = 1'b1;
    if_ready = 1'b0;
    lat_min = 1;
    lat_max = 1;
    repeat (10) tick();
    nchk++;
    if (req_log.size() != 2) begin
      nerr++; $display("FAIL bp_req_count got %0d want 2", req_log.size());
    end else begin
      nchk++;
      if (req_log[0] !== 32'h0 || req_log[1] !== 32'h4) begin
        nerr++; $display("FAIL bp_req_addr got %0h,%0h want 0,4", req_log[0], req_log[1]);
      end
    end
    nchk++;
    if (s_rv !== 1'b0 || s_iv !== 1'b1 || s_ipc !== 32'h0) begin
      nerr++; $display("FAIL bp_hold got rv=%0h iv=%0h pc=%0h want 0,1,0", s_rv, s_iv, s_ipc);
    end
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;
    repeat (3) tick();
    nchk++;
    if (req_log.size() != 3 || req_log[2] !== 32'h8) begin
      nerr++; $display("FAIL bp_refill got n=%0d want 3 with addr 8", req_log.size());
    end
  endtask

  task automatic test_redirect();
    logic [31:0] e;
    do_reset();
    imem_req_ready = 1'b1;
    if_ready = 1'b1;
    lat_min = 3;
    lat_max = 3;
    tick();
    tick();
    tick();
    clear_logs();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    tick();
    nchk++;
    if (s_rv !== 1'b0) begin
      nerr++; $display("FAIL redir_no_req got %0h want 0", s_rv);
    end
    repeat (20) tick();
    nchk++;
    if (req_log.size() < 1 || req_log[0] !== 32'h100) begin
      nerr++; $display("FAIL redir_req got n=%0d want first 100", req_log.size());
    end
    nchk++;
    if (dl_pc.size() < 2) begin
      nerr++; $display("FAIL redir_count got %0d want >=2", dl_pc.size());
    end
    e = 32'h100;
    for (int i = 0; i < dl_pc.size(); i++) begin
      nchk++;
      if (dl_pc[i] !== e || dl_in[i] !== mem_word(e)) begin
        nerr++; $display("FAIL redir_stream[%0d] got %0h want %0h", i, dl_pc[i], e);
      end
      e += 32'd4;
    end
  endtask

  task automatic test_align_wrap();
    logic [31:0] e;
    do_reset();
    imem_req_ready = 1'b1;
    if_ready = 1'b1;
    lat_min = 1;
    lat_max = 1;
    tick();
    tick();
    clear_logs();
    redirect_valid = 1'b1;
    redirect_pc = 32'h203;
    tick();
    nchk++;
    if (s_rv !== 1'b0) begin
      nerr++; $display("FAIL align_forced0 got %0h want 0", s_rv);
    end
    tick();
    nchk++;
    if (s_rv !== 1'b1 || s_ra !== 32'h200) begin
      nerr++; $display("FAIL align_req got v=%0h a=%0h want 1/200", s_rv, s_ra);
    end
    repeat (10) tick();
    nchk++;
    if (dl_pc.size() < 1 || dl_pc[0] !== 32'h200) begin
      nerr++; $display("FAIL align_deliv got n=%0d want first 200", dl_pc.size());
    end
    clear_logs();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    repeat (14) tick();
    nchk++;
    if (req_log.size() < 4 || dl_pc.size() < 3) begin
      nerr++; $display("FAIL wrap_count got %0d/%0d want >=4/>=3", req_log.size(), dl_pc.size());
    end else begin
      e = 32'hFFFF_FFF8;
      for (int i = 0; i < 4; i++) begin
        nchk++;
        if (req_log[i] !== e) begin
          nerr++; $display("FAIL wrap_req[%0d] got %0h want %0h", i, req_log[i], e);
        end
        e += 32'd4;
      end
      e = 32'hFFFF_FFF8;
      for (int i = 0; i < 3; i++) begin
        nchk++;
        if (dl_pc[i] !== e || dl_in[i] !== mem_word(e)) begin
          nerr++; $display("FAIL wrap_deliv[%0d] got %0h want %0h", i, dl_pc[i], e);
        end
        e += 32'd4;
      end
    end
  endtask

  task automatic test_halt();
    bit seen;
    int hc;
    do_reset();
    imem_req_ready = 1'b1;
    if_ready = 1'b1;
    lat_min = 3;
    lat_max = 3;
    tick();
    tick();
    halt_req = 1'b1;
    tick();
    nchk++;
    if (s_rv !== 1'b0) begin
      nerr++; $display("FAIL halt_no_issue got %0h want 0", s_rv);
    end
    seen = 1'b0;
    hc = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (s_h === 1'b1) begin
        seen = 1'b1;
        hc = s_cyc;
      end
    end
    nchk++;
    if (!seen) begin
      nerr++; $display("FAIL halt_timeout got halted=0 want 1 within 20 cycles");
    end
    nchk++;
    if (hc != last_rsp + 2) begin
      nerr++; $display("FAIL halt_timing got cycle %0d want %0d", hc, last_rsp + 2);
    end
    nchk++;
    if (dl_pc.size() != 1 || dl_pc[0] !== 32'h0) begin
      nerr++; $display("FAIL halt_drain got n=%0d want 1 entry pc 0", dl_pc.size());
    end
    repeat (5) tick();
    nchk++;
    if (req_log.size() != 1 || s_h !== 1'b1) begin
      nerr++; $display("FAIL halt_hold got reqs=%0d h=%0h want 1/1", req_log.size(), s_h);
    end
    halt_req = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    tick();
    tick();
    nchk++;
    if (s_rv !== 1'b1 || s_ra !== 32'h40) begin
      nerr++; $display("FAIL resume_req got v=%0h a=%0h want 1/40", s_rv, s_ra);
    end
    repeat (8) tick();
    nchk++;
    if (dl_pc.size() < 2 || dl_pc[1] !== 32'h40) begin
      nerr++; $display("FAIL resume_deliv got n=%0d want second pc 40", dl_pc.size());
    end
  endtask

  task automatic test_stall_reset();
    bit got;
    logic [31:0] a;
    do_reset();
    imem_req_ready = 1'b1;
    if_ready = 1'b1;
    lat_min = 1;
    lat_max = 1;
    repeat (8) tick();
    imem_req_ready = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      got = (s_rv === 1'b1);
    end
    nchk++;
    if (!got) begin
      nerr++; $display("FAIL stall_timeout got valid=0 want 1 within 10 cycles");
    end
    a = s_ra;
    for (int i = 0; i < 5; i++) begin
      tick();
      nchk++;
      if (s_rv !== 1'b1 || s_ra !== a) begin
        nerr++; $display("FAIL stall_hold[%0d] got v=%0h a=%0h want 1/%0h", i, s_rv, s_ra, a);
      end
    end
    rst_n = 1'b0;
    tick();
    nchk++;
    if (s_rv !== 1'b0 || s_ra !== 32'h0 || s_iv !== 1'b0
        || s_ipc !== 32'h0 || s_iin !== 32'h0 || s_h !== 1'b0) begin
      nerr++; $display("FAIL mid_reset got rv=%0h ra=%0h iv=%0h pc=%0h h=%0h want all 0", s_rv, s_ra, s_iv, s_ipc, s_h);
    end
    tick();
    rst_n = 1'b1;
    imem_req_ready = 1'b1;
    clear_logs();
    tick();
    tick();
    nchk++;
    if (s_rv !== 1'b1 || s_ra !== 32'h0) begin
      nerr++; $display("FAIL restart got v=%0h a=%0h want 1/0", s_rv, s_ra);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] exp_req;
    logic [31:0] tgt;
    logic        redir;
    int          ndl;
    do_reset();
    lat_min = 1;
    lat_max = 4;
    exp_pc = 32'h0;
    exp_req = 32'h0;
    ndl = 0;
    for (int n = 0; n < 800; n++) begin
      imem_req_ready = ($urandom_range(3, 0) != 0);
      if_ready = ($urandom_range(9, 0) < 7);
      redir = ($urandom_range(39, 0) == 0);
      tgt = $urandom();
      redirect_valid = redir;
      redirect_pc = tgt;
      tick();
      while (req_log.size() > 0) begin
        nchk++;
        if (req_log[0] !== exp_req) begin
          nerr++; $display("FAIL rnd_req got %0h want %0h", req_log[0], exp_req);
        end
        exp_req += 32'd4;
        req_log.delete(0);
      end
      while (dl_pc.size() > 0) begin
        nchk++;
        if (dl_pc[0] !== exp_pc || dl_in[0] !== mem_word(exp_pc)) begin
          nerr++; $display("FAIL rnd_deliv got %0h/%0h want %0h/%0h", dl_pc[0], dl_in[0], exp_pc, mem_word(exp_pc));
        end
        exp_pc += 32'd4;
        ndl++;
        dl_pc.delete(0);
        dl_in.delete(0);
      end
      if (redir) begin
        exp_pc = {tgt[31:2], 2'b00};
        exp_req = {tgt[31:2], 2'b00};
      end
    end
    nchk++;
    if (max_pend > DEPTH) begin
      nerr++; $display("FAIL rnd_inflight got %0d want <=%0d", max_pend, DEPTH);
    end
    nchk++;
    if (ndl < 50) begin
      nerr++; $display("FAIL rnd_progress got %0d want >=50", ndl);
    end
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    cyc = 0;
    last_due = 0;
    last_rsp = 0;
    max_pend = 0;
    lat_min = 1;
    lat_max = 1;
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    halt_req = 1'b0;
    if_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect();
    test_align_wrap();
    test_halt();
    test_stall_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
